decode_queue: RTL
=================

# decode_queue

Parametrised, buffered successor to the combinational RV32I instruction decoder. It accepts fetched instructions over a valid/ready handshake and decodes each one on entry. The decoded bundles sit in a DEPTH-entry circular queue, and the head entry is presented downstream over a second valid/ready handshake. It sits between fetch and register read, absorbs fetch/execute rate mismatch, supports pipeline flush and flags illegal encodings.

## Interface

- DEPTH, 4, number of queue entries; power of two, ≥ 2
- CHECK_ILLEGAL, 1, 1 = run full illegal-encoding check; 0 = only unknown opcodes are illegal

- clk  input  1  sole clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  in_instr/in_pc valid
- in_ready  output  1  queue can accept this cycle
- in_instr  input  32  raw instruction word
- in_pc  input  32  PC of in_instr
- flush  input  1  discard all queued entries
- out_valid  output  1  head entry valid
- out_ready  input  1  consumer takes head this cycle
- out_pc  output  32  PC of head
- out_opcode  output  7  instr[6:0]
- out_funct3  output  3  funct3 per decode rules
- out_funct7  output  7  funct7 per decode rules
- out_rd, out_rs1, out_rs2  output  5 each  register indices per decode rules
- out_imm  output  32  sign/zero-extended immediate
- out_illegal  output  1  head encoding is illegal
- count  output  $clog2(DEPTH)+1  occupied entries

## Operation

- Opcodes: RType 0110011, IType_logic 0010011, IType_load 0000011, IType_jalr 1100111, SType 0100011, BType 1100011, JType 1101111, UType_auipc 0010111, UType_lui 0110111, FENCE 0001111.
- funct3 is instr[14:12] for R, I-logic, load, jalr, S and B. funct7 is instr[31:25] for R and I-logic. Both are 0 otherwise.
- rd is instr[11:7] for R, I-logic, load, jalr, U and J.
- rs1 is instr[19:15] for R, I-logic, load, jalr, S and B.
- rs2 is instr[24:20] for R, S and B.
- Unused register fields are 0.
- Immediate by format:
  - I: sext(instr[31:20]).
  - S: sext({instr[31:25], instr[11:7]}).
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - U: {instr[31:12], 12'b0}.
  - R and FENCE: 0.
- Illegal encodings:
  - Opcode not in the list above.
  - When CHECK_ILLEGAL=1, also: RType with funct7 ∉ {0000000, 0100000}; RType with funct7=0100000 and funct3 ∉ {000, 101}; jalr with funct3≠000; load with funct3 ∈ {011, 110, 111}; store with funct3 > 010; branch with funct3 ∈ {010, 011}.
- Illegal entries are still enqueued with out_illegal=1 and opcode/pc preserved. All other fields and imm are forced to 0.
- Enqueue: in_valid && in_ready && !flush writes the decoded bundle at the write pointer.
- Dequeue: out_valid && out_ready && !flush advances the read pointer.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
- Simultaneous enqueue and dequeue leave count unchanged. This is legal when the queue is neither empty nor full; when full, in_ready=0 so no enqueue happens.
- Flush has priority: at the next edge count=0 and pointers reset to 0, and any same-cycle enqueue or dequeue is dropped.

## Timing

- Reset (async, while rst_n=0):
  - Pointers and count are 0.
  - out_valid=0.
  - in_ready=1.
  - All out_* data fields are 0.
- in_ready = (count < DEPTH). It is registered-state only, with no combinational path from out_ready.
- out_valid = (count ≠ 0).
- out_* data come from the head entry and are forced to 0 while count=0.
- Latency: an instruction accepted at edge N is visible on out_* with out_valid=1 after edge N. There is no empty-queue bypass in the same cycle.
- Throughput: 1 instruction per cycle sustained when out_ready=1.
- Head fields stay stable while out_valid=1 and out_ready=0.
- If rst_n is asserted mid-operation, all contents are discarded immediately; the next accepted instruction enters an empty queue.

## Test plan

- addi x1,x0,5 (0x00500093), pc 0x100, queue empty, out_ready=1 -> one cycle later: out_valid=1, opcode 0010011, rd=1, rs1=0, funct3=0, imm=0x00000005, illegal=0, pc 0x100.
- beq x1,x2,-4 (0xFE208EE3) -> rs1=1, rs2=2, rd=0, funct3=0, imm=0xFFFFFFFC.
- Push DEPTH+1 instructions back-to-back with out_ready=0 -> count reaches DEPTH, in_ready=0 on the last push, and the extra word is not accepted. Then hold out_ready=1 -> entries drain in order with PCs matching, then out_valid=0 and count=0.
- Hold in_valid=1 and out_ready=1 with count=2 for 10 cycles -> count stays 2, order is preserved and pointers wrap at DEPTH.
- 0xFFFFFFFF -> illegal=1, all fields 0. mul 0x02208033 with CHECK_ILLEGAL=1 -> illegal=1; with CHECK_ILLEGAL=0 -> illegal=0 and funct7=0000001.
- Flush with count=3 and concurrent in_valid=1 -> next cycle count=0, out_valid=0, nothing enqueued. Drop rst_n mid-stream -> outputs go to reset values immediately.

Source files
------------

// File: rtl/decode_queue_if.sv
// decode_queue_if: fetch-side and register-read-side handshake bundle for decode_queue
interface decode_queue_if #(parameter int DEPTH = 4);
  logic in_valid, in_ready, flush, out_valid, out_ready, out_illegal;
  logic [31:0] in_instr, in_pc, out_pc, out_imm;
  logic [6:0] out_opcode, out_funct7;
  logic [2:0] out_funct3;
  logic [4:0] out_rd, out_rs1, out_rs2;
  logic [$clog2(DEPTH):0] count;
  modport master(
    output in_valid, in_instr, in_pc, flush, out_ready,
    input in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
    input out_rd, out_rs1, out_rs2, out_imm, out_illegal, count
  );
  modport slave(
    input in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
    output out_rd, out_rs1, out_rs2, out_imm, out_illegal, count
  );
endinterface

// File: rtl/decode_queue.sv
// decode_queue: RV32I decode-on-entry circular queue between fetch and register read
module decode_queue #(
  parameter int DEPTH = 4,
  parameter bit CHECK_ILLEGAL = 1'b1
) (
  input logic clk,
  input logic rst_n,
  decode_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef struct packed {
    logic [31:0] pc;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd, rs1, rs2;
    logic [31:0] imm;
    logic ill;
  } entry_t;
  entry_t mem [DEPTH];
  entry_t dec, head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt;
  logic enq, deq;
  logic [31:0] ins;
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic is_r, is_il, is_ld, is_jalr, is_s, is_b, is_j, is_auipc, is_lui, is_fence;
  logic known, bad, ill;
  assign ins = bus.in_instr;
  assign op = ins[6:0];
  assign f3 = ins[14:12];
  assign f7 = ins[31:25];
  always_comb begin
    is_r = op == 7'b0110011;
    is_il = op == 7'b0010011;
    is_ld = op == 7'b0000011;
    is_jalr = op == 7'b1100111;
    is_s = op == 7'b0100011;
    is_b = op == 7'b1100011;
    is_j = op == 7'b1101111;
    is_auipc = op == 7'b0010111;
    is_lui = op == 7'b0110111;
    is_fence = op == 7'b0001111;
    known = is_r | is_il | is_ld | is_jalr | is_s | is_b | is_j | is_auipc | is_lui | is_fence;
    bad = (is_r && f7 != 7'h00 && f7 != 7'h20) ||
          (is_r && f7 == 7'h20 && f3 != 3'd0 && f3 != 3'd5) ||
          (is_jalr && f3 != 3'd0) ||
          (is_ld && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) ||
          (is_s && f3 > 3'd2) ||
          (is_b && (f3 == 3'd2 || f3 == 3'd3));
    ill = !known || (CHECK_ILLEGAL && bad);
    dec = '0;
    dec.pc = bus.in_pc;
    dec.op = op;
    dec.ill = ill;
    dec.f3 = (!ill && (is_r | is_il | is_ld | is_jalr | is_s | is_b)) ? f3 : '0;
    dec.f7 = (!ill && (is_r | is_il)) ? f7 : '0;
    dec.rd = (!ill && (is_r | is_il | is_ld | is_jalr | is_auipc | is_lui | is_j)) ? ins[11:7] : '0;
    dec.rs1 = (!ill && (is_r | is_il | is_ld | is_jalr | is_s | is_b)) ? ins[19:15] : '0;
    dec.rs2 = (!ill && (is_r | is_s | is_b)) ? ins[24:20] : '0;
    dec.imm = ill ? '0 :
              (is_il | is_ld | is_jalr) ? {{20{ins[31]}}, ins[31:20]} :
              is_s ? {{20{ins[31]}}, ins[31:25], ins[11:7]} :
              is_b ? {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0} :
              is_j ? {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0} :
              (is_auipc | is_lui) ? {ins[31:12], 12'b0} : '0;
  end
  assign bus.in_ready = cnt < FULL;
  assign bus.out_valid = cnt != '0;
  assign enq = bus.in_valid && bus.in_ready && !bus.flush;
  assign deq = bus.out_valid && bus.out_ready && !bus.flush;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
    end else begin
      wr_ptr <= enq ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= deq ? rd_ptr + AW'(1) : rd_ptr;
      cnt <= cnt + (AW+1)'(enq) - (AW+1)'(deq);
    end
  end
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= dec;
  end
  assign head = bus.out_valid ? mem[rd_ptr] : '0;
  assign bus.out_pc = head.pc;
  assign bus.out_opcode = head.op;
  assign bus.out_funct3 = head.f3;
  assign bus.out_funct7 = head.f7;
  assign bus.out_rd = head.rd;
  assign bus.out_rs1 = head.rs1;
  assign bus.out_rs2 = head.rs2;
  assign bus.out_imm = head.imm;
  assign bus.out_illegal = head.ill;
  assign bus.count = cnt;
endmodule
